// File: rtl/bus_term_pkg.sv
// bus_term_pkg: shared addressing constants, destination extraction and bench-visible enums
package bus_term_pkg;
  localparam int ADDR_W = 8;
  localparam logic [ADDR_W-1:0] BCAST_ID = 8'hFF;
  localparam int PKT_MAX = 256;
  typedef enum logic [1:0] {TRANS_ENVIO, TRANS_BROADCAST, TRANS_RESET, TRANS_LECTURA} tipos_de_transaccion;
  typedef enum logic [2:0] {LLENADO_ALEATORIO, TRANS_ALEATORIA, TRANS_ESPECIFICA, ENVIO_BROADCAST, ERRORES} cas_esq;
  // pkt is a zero-extended packet of width w; the destination is its top ADDR_W bits
  function automatic logic [ADDR_W-1:0] get_dest(input logic [PKT_MAX-1:0] pkt, input int w);
    return ADDR_W'(pkt >> (w - ADDR_W));
  endfunction
endpackage

// File: rtl/sync_fifo_core.sv
// sync_fifo_core: show-ahead synchronous FIFO; push while full is accepted when a pop happens the same cycle
// ports: clk, reset (sync high), push_i/pop_i requests, data_i in, full_o/empty_o flags, head_o oldest entry
module sync_fifo_core #(
  parameter int W = 32,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic push_ok, pop_ok;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign head_o = mem_q[rd_ptr_q];
  always_comb begin
    pop_ok = pop_i && !empty_o;
    push_ok = push_i && (!full_o || pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
endmodule

// File: rtl/bus_terminal_fifo.sv
// bus_terminal_fifo: terminal-side bus FIFO pair with destination filter, registered RX read and saturating stats
// ports: TX wr_en/wr_data/tx_full -> pndng/D_pop/pop; RX push/D_push -> rd_en/rd_data/rd_valid/rx_empty; four error counters
module bus_terminal_fifo import bus_term_pkg::*; #(
  parameter int tama_de_paquete = 32,
  parameter int DEPTH = 16,
  parameter logic [7:0] MY_ID = 8'h00,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [tama_de_paquete-1:0] wr_data,
  output logic                       tx_full,
  output logic                       pndng,
  output logic [tama_de_paquete-1:0] D_pop,
  input  logic                       pop,
  input  logic                       push,
  input  logic [tama_de_paquete-1:0] D_push,
  input  logic                       rd_en,
  output logic [tama_de_paquete-1:0] rd_data,
  output logic                       rd_valid,
  output logic                       rx_empty,
  output logic [CNT_W-1:0]           tx_ovf_cnt,
  output logic [CNT_W-1:0]           rx_ovf_cnt,
  output logic [CNT_W-1:0]           rx_drop_cnt,
  output logic [CNT_W-1:0]           pop_err_cnt
);
  logic tx_empty, rx_full, hit, rd_ok;
  logic [ADDR_W-1:0] dest;
  logic [tama_de_paquete-1:0] tx_head, rx_head, rd_data_q, rd_data_d;
  logic rd_valid_q, rd_valid_d;
  logic [3:0] ev;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  sync_fifo_core #(.W(tama_de_paquete), .DEPTH(DEPTH)) u_tx (
    .clk(clk), .reset(reset), .push_i(wr_en), .pop_i(pop), .data_i(wr_data),
    .full_o(tx_full), .empty_o(tx_empty), .head_o(tx_head)
  );
  sync_fifo_core #(.W(tama_de_paquete), .DEPTH(DEPTH)) u_rx (
    .clk(clk), .reset(reset), .push_i(push && hit), .pop_i(rd_en), .data_i(D_push),
    .full_o(rx_full), .empty_o(rx_empty), .head_o(rx_head)
  );
  assign pndng = !tx_empty;
  assign D_pop = pndng ? tx_head : '0;
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign {pop_err_cnt, rx_drop_cnt, rx_ovf_cnt, tx_ovf_cnt} = cnt_q;
  always_comb begin
    dest = get_dest(PKT_MAX'(D_push), tama_de_paquete);
    hit = dest == MY_ID || dest == BCAST_ID;
    rd_ok = rd_en && !rx_empty;
    rd_data_d = rd_ok ? rx_head : rd_data_q;
    rd_valid_d = rd_ok;
    ev[0] = wr_en && tx_full && !pop;
    ev[1] = push && hit && rx_full && !rd_ok;
    ev[2] = push && !hit;
    ev[3] = pop && tx_empty;
    for (int i = 0; i < 4; i++) cnt_d[i] = cnt_q[i] + CNT_W'(ev[i] && !(&cnt_q[i]));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
